fetch_stage: RTL and testbench

Instruction fetch stage for the pipelined MIPS core. It generates the program counter, issues word requests to instruction memory, and buffers returned instructions in a 2-entry queue. The queue supplies the decode stage's instruction input under a valid/stall handshake. Branch and jump redirects from later stages flush in-flight and queued instructions.

---
 rtl/fetch_stage.sv | 92 +++++++++
 tb/tb_fetch_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction fetch with PC generation, one outstanding imem request and a 2-entry instruction queue
//   clk_i/rst_i             clock (rising edge) and asynchronous active-low reset
//   imem_req_o/imem_addr_o  single-cycle request strobe and word address (the fetch PC)
//   imem_ack_i/imem_data_i  one response per request, at least 1 cycle after it
//   redirect_i/redirect_pc_i flush everything and restart fetch at redirect_pc_i
//   stall_i                 decode cannot accept the queue head this cycle
//   inst_o/pc_o/pc_plus4_o  queue head, all zero while inst_valid_o=0
//   bubble_cnt_o            only with FETCH_BUBBLE_CNT_EN: cycles out of reset with an empty queue
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
`ifdef FETCH_BUBBLE_CNT_EN
    output logic [31:0] bubble_cnt_o,
`endif
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o
);
    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
    state_t      state, state_nxt;
    logic [31:0] fpc;
    logic [1:0]  count, fill;
    logic [31:0] q_inst [2];
    logic [31:0] q_pc [2];
    logic        pop, push, issue, wr_idx;
    assign inst_valid_o = count != 2'd0;
    assign pop          = inst_valid_o && !stall_i && !redirect_i;
    assign push         = imem_ack_i && state == WAIT && !redirect_i;
    assign fill         = count - {1'b0, pop} + {1'b0, push};
    // a request needs a slot still free once its response arrives
    assign issue        = rst_i && !redirect_i && (state == IDLE || (state == WAIT && imem_ack_i)) && fill < 2'd2;
    assign wr_idx       = count == 2'd1 && !pop;
    assign imem_req_o   = issue;
    assign imem_addr_o  = fpc;
    assign inst_o       = inst_valid_o ? q_inst[0] : 32'd0;
    assign pc_o         = inst_valid_o ? q_pc[0] : 32'd0;
    assign pc_plus4_o   = inst_valid_o ? q_pc[0] + 32'd4 : 32'd0;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = issue ? WAIT : IDLE;
            WAIT:    state_nxt = imem_ack_i ? (issue ? WAIT : IDLE) : (redirect_i ? DROP : WAIT);
            DROP:    state_nxt = imem_ack_i ? IDLE : DROP;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            fpc       <= RESET_PC;
            count     <= 2'd0;
            q_inst[0] <= 32'd0;
            q_inst[1] <= 32'd0;
            q_pc[0]   <= 32'd0;
            q_pc[1]   <= 32'd0;
        end else begin
            state <= state_nxt;
            count <= redirect_i ? 2'd0 : fill;
            if (redirect_i)
                fpc <= redirect_pc_i;
            else if (issue)
                fpc <= fpc + 32'd4;
            if (pop) begin
                q_inst[0] <= q_inst[1];
                q_pc[0]   <= q_pc[1];
            end
            // in WAIT fpc has already advanced past the outstanding request
            if (push) begin
                q_inst[wr_idx] <= imem_data_i;
                q_pc[wr_idx]   <= fpc - 32'd4;
            end
        end
    end
`ifdef FETCH_BUBBLE_CNT_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            bubble_cnt_o <= 32'd0;
        else if (!inst_valid_o)
            bubble_cnt_o <= bubble_cnt_o + 32'd1;
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and random checks of fetch_stage against a program-order stream model
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_data_i = 32'd0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'd0;
    logic        stall_i = 1'b0;
    logic        imem_req_o, inst_valid_o;
    logic [31:0] imem_addr_o, inst_o, pc_o, pc_plus4_o;
`ifdef FETCH_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt_o;
    logic [31:0] bub;
`endif

    fetch_stage dut (
        .clk_i(clk), .rst_i(rst_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .stall_i(stall_i),
`ifdef FETCH_BUBBLE_CNT_EN
        .bubble_cnt_o(bubble_cnt_o),
`endif
        .inst_o(inst_o), .inst_valid_o(inst_valid_o),
        .pc_o(pc_o), .pc_plus4_o(pc_plus4_o)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0, n_bad = 0, cyc = 0, lat = 1, n_pop = 0;
    int          pdue[$];
    logic [31:0] paddr[$];
    logic [31:0] exp_req = 32'd0, exp_pc = 32'd0;
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_p4, s_inst;

    // memory contents: any fixed, nonzero, address-dependent word
    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5EED_C0DE;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive inputs and memory response, then check against the stream model.
    // Expected fetch order is program order restarting at every redirect/reset; every valid head
    // must be the next expected PC with the word memory holds there.
    task automatic cycle(input logic r, input logic st, input logic rd, input logic [31:0] rpc);
        @(negedge clk);
        rst_i = r; stall_i = st; redirect_i = rd; redirect_pc_i = rpc;
        imem_ack_i = 1'b0; imem_data_i = 32'd0;
        if (pdue.size() > 0 && pdue[0] <= cyc) begin
            imem_ack_i = 1'b1;
            imem_data_i = mem(paddr[0]);
            void'(pdue.pop_front());
            void'(paddr.pop_front());
        end
        #1;
        s_req = imem_req_o; s_addr = imem_addr_o; s_valid = inst_valid_o;
        s_pc = pc_o; s_p4 = pc_plus4_o; s_inst = inst_o;
        if (!r) begin
            chk("rst_req", {31'd0, s_req}, 32'd0);
            chk("rst_valid", {31'd0, s_valid}, 32'd0);
            chk("rst_outputs", s_inst | s_pc | s_p4, 32'd0);
`ifdef FETCH_BUBBLE_CNT_EN
            chk("rst_bubble", bubble_cnt_o, 32'd0);
            bub = 32'd0;
`endif
            exp_req = 32'd0;
            exp_pc = 32'd0;
        end else begin
            if (s_valid) begin
                chk("pc_o", s_pc, exp_pc);
                chk("inst_o", s_inst, mem(s_pc));
                chk("pc_plus4_o", s_p4, s_pc + 32'd4);
            end else
                chk("empty_outputs", s_inst | s_pc | s_p4, 32'd0);
`ifdef FETCH_BUBBLE_CNT_EN
            chk("bubble_cnt", bubble_cnt_o, bub);
            if (!s_valid) bub = bub + 32'd1;
`endif
            if (rd) begin
                chk("req_on_redirect", {31'd0, s_req}, 32'd0);
                exp_req = rpc;
                exp_pc = rpc;
            end else begin
                if (s_valid && !st) begin
                    exp_pc = exp_pc + 32'd4;
                    n_pop++;
                end
                if (s_req) begin
                    chk("imem_addr_o", s_addr, exp_req);
                    chk("outstanding", 32'(pdue.size()), 32'd0);
                    pdue.push_back(cyc + lat);
                    paddr.push_back(s_addr);
                    exp_req = exp_req + 32'd4;
                end
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 8 && pdue.size() > 0; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        // back-to-back fetch with 1-cycle memory
        lat = 1; do_reset();
        cycle(1, 0, 0, 0); chk("t1_c0_req", {31'd0, s_req}, 32'd1); chk("t1_c0_addr", s_addr, 32'h0);
        cycle(1, 0, 0, 0); chk("t1_c1_addr", s_addr, 32'h4); chk("t1_c1_valid", {31'd0, s_valid}, 32'd0);
        cycle(1, 0, 0, 0); chk("t1_c2_valid", {31'd0, s_valid}, 32'd1); chk("t1_c2_pc", s_pc, 32'h0);
        chk("t1_c2_p4", s_p4, 32'h4); chk("t1_c2_addr", s_addr, 32'h8);
        cycle(1, 0, 0, 0); chk("t1_c3_pc", s_pc, 32'h4); chk("t1_c3_p4", s_p4, 32'h8);
        cycle(1, 0, 0, 0); chk("t1_c4_pc", s_pc, 32'h8); chk("t1_c4_p4", s_p4, 32'hC);
        // stall 5 cycles holding the first instruction
        do_reset();
        run(2);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 1, 0, 0);
            chk("t2_stall_req", {31'd0, s_req}, 32'd0);
            chk("t2_stall_pc", s_pc, 32'h0);
            chk("t2_stall_inst", s_inst, mem(32'h0));
        end
        cycle(1, 0, 0, 0); chk("t2_rel_pc", s_pc, 32'h0); chk("t2_rel_addr", s_addr, 32'h8);
        cycle(1, 0, 0, 0); chk("t2_next_pc", s_pc, 32'h4);
        cycle(1, 0, 0, 0); chk("t2_next2_pc", s_pc, 32'h8);
        // slow memory: ack 4 cycles after request, 3 bubbles between instructions
        lat = 4; do_reset();
        cycle(1, 0, 0, 0); chk("t3_req0", s_addr, 32'h0);
        for (int i = 0; i < 4; i++) begin cycle(1, 0, 0, 0); chk("t3_wait_valid", {31'd0, s_valid}, 32'd0); end
        cycle(1, 0, 0, 0); chk("t3_pc0", s_pc, 32'h0);
        for (int i = 0; i < 3; i++) begin cycle(1, 0, 0, 0); chk("t3_bubble_valid", {31'd0, s_valid}, 32'd0); end
        cycle(1, 0, 0, 0); chk("t3_pc4", s_pc, 32'h4);
        // redirect while the request to 0x8 is outstanding
        lat = 2; do_reset();
        run(5);
        cycle(1, 0, 1, 32'h100); chk("t4_redir_head", s_pc, 32'h4); chk("t4_redir_req", {31'd0, s_req}, 32'd0);
        cycle(1, 0, 0, 0); chk("t4_drop_valid", {31'd0, s_valid}, 32'd0); chk("t4_drop_req", {31'd0, s_req}, 32'd0);
        cycle(1, 0, 0, 0); chk("t4_new_req", {31'd0, s_req}, 32'd1); chk("t4_new_addr", s_addr, 32'h100);
        run(2);
        cycle(1, 0, 0, 0); chk("t4_first_valid", s_pc, 32'h100);
        // redirect coincident with the 0xC ack, stalled, one entry queued
        lat = 1; do_reset();
        run(4);
        cycle(1, 1, 1, 32'h200); chk("t5_head", s_pc, 32'h8); chk("t5_ack_seen", {31'd0, imem_ack_i}, 32'd1);
        cycle(1, 0, 0, 0); chk("t5_flushed", {31'd0, s_valid}, 32'd0); chk("t5_addr", s_addr, 32'h200);
        run(1);
        cycle(1, 0, 0, 0); chk("t5_pc", s_pc, 32'h200);
        // redirect to the top word: pc_plus4 and fetch address wrap to 0
        cycle(1, 0, 1, 32'hFFFF_FFFC);
        cycle(1, 0, 0, 0); chk("t6_addr", s_addr, 32'hFFFF_FFFC);
        cycle(1, 0, 0, 0); chk("t6_wrap_addr", s_addr, 32'h0);
        cycle(1, 0, 0, 0); chk("t6_pc", s_pc, 32'hFFFF_FFFC); chk("t6_p4", s_p4, 32'h0);
        cycle(1, 0, 0, 0); chk("t6_pc_wrap", s_pc, 32'h0);
        // reset while a request is outstanding; its ack lands in the first cycle after reset
        lat = 3;
        for (int i = 0; i < 10; i++) begin
            cycle(1, 0, 0, 0);
            if (s_req) break;
        end
        chk("t7_found_req", {31'd0, s_req}, 32'd1);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0); chk("t7_late_ack", {31'd0, imem_ack_i}, 32'd1); chk("t7_req0", s_addr, 32'h0);
        for (int i = 0; i < 3; i++) begin cycle(1, 0, 0, 0); chk("t7_no_stale", {31'd0, s_valid}, 32'd0); end
        cycle(1, 0, 0, 0); chk("t7_pc0", s_pc, 32'h0);
        // random stalls, redirects and memory latency
        n_pop = 0;
        for (int i = 0; i < 800; i++) begin
            if (i % 50 == 0) lat = $urandom_range(1, 3);
            cycle(1, $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, $urandom);
        end
        chk("progress", {31'd0, n_pop > 100}, 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
